// File: rtl/sram_wb_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sram_wb_ctrl_pkg
// Purpose  : Shared constants and FSM state encoding for the external
//            asynchronous SRAM Wishbone controller.
// Revision : 1.0 - initial release
// ============================================================================
package sram_wb_ctrl_pkg;

  // Three-bit state codes; kept as plain constants so other blocks can decode them
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_READ   = 3'd1;
  localparam logic [2:0] ST_WSETUP = 3'd2;
  localparam logic [2:0] ST_WPULSE = 3'd3;
  localparam logic [2:0] ST_WHOLD  = 3'd4;
  localparam logic [2:0] ST_ACK    = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_READ   = ST_READ,
    S_WSETUP = ST_WSETUP,
    S_WPULSE = ST_WPULSE,
    S_WHOLD  = ST_WHOLD,
    S_ACK    = ST_ACK
  } state_e;

  // Top address nibble decoded by the interconnect for this slave (0x4xxxxxxx)
  localparam logic [3:0] SRAM_BASE = 4'h4;

  // Shortest legal OE / WE hold time in clock cycles
  localparam int MIN_WAIT = 1;

  // Larger of two integers, used to size the wait counter
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sram_wb_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sram_wb_ctrl
// Purpose  : Wishbone classic slave driving two 256Kx16 asynchronous SRAMs
//            as one 32-bit memory, with registered strobes and
//            programmable read / write wait states.
// Revision : 1.0 - initial release
// ============================================================================
module sram_wb_ctrl
  import sram_wb_ctrl_pkg::*;
#(
  parameter int ADR_WIDTH = 18,
  parameter int RD_WAIT   = 2,
  parameter int WR_WAIT   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wb_cyc_i,
  input  logic                 wb_stb_i,
  input  logic                 wb_we_i,
  input  logic [31:0]          wb_adr_i,
  input  logic [3:0]           wb_sel_i,
  input  logic [31:0]          wb_dat_i,
  output logic [31:0]          wb_dat_o,
  output logic                 wb_ack_o,
  output logic [ADR_WIDTH-1:0] sram_adr,
  output logic [31:0]          sram_dat_o,
  input  logic [31:0]          sram_dat_i,
  output logic                 sram_dat_oe,
  output logic [1:0]           sram_ce_n,
  output logic                 sram_oe_n,
  output logic                 sram_we_n,
  output logic [1:0]           sram_ub_n,
  output logic [1:0]           sram_lb_n
);

  // Out-of-range wait settings are clamped up to the minimum legal value
  localparam int RD_EFF  = (RD_WAIT < MIN_WAIT) ? MIN_WAIT : RD_WAIT;
  localparam int WR_EFF  = (WR_WAIT < MIN_WAIT) ? MIN_WAIT : WR_WAIT;
  localparam int CNT_MAX = max_int(RD_EFF, WR_EFF);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_EFF - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_EFF - 1);

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [ADR_WIDTH-1:0]   adr_q, adr_d;
  logic [31:0]            dat_o_q, dat_o_d;
  logic [31:0]            rdata_q, rdata_d;
  logic                   dat_oe_q, dat_oe_d;
  logic [1:0]             ce_n_q, ce_n_d;
  logic                   oe_n_q, oe_n_d;
  logic                   we_n_q, we_n_d;
  logic [1:0]             ub_n_q, ub_n_d;
  logic [1:0]             lb_n_q, lb_n_d;
  logic                   ack_q, ack_d;

  // Address bits outside the word window are intentionally ignored (aliasing)
  logic unused_adr;
  assign unused_adr = ^{wb_adr_i[31:ADR_WIDTH+2], wb_adr_i[1:0]};

  // Next-state and next-output logic; every strobe is decided one edge ahead
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    adr_d    = adr_q;
    dat_o_d  = dat_o_q;
    rdata_d  = rdata_q;
    dat_oe_d = dat_oe_q;
    ce_n_d   = ce_n_q;
    oe_n_d   = oe_n_q;
    we_n_d   = we_n_q;
    ub_n_d   = ub_n_q;
    lb_n_d   = lb_n_q;
    ack_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (wb_cyc_i && wb_stb_i) begin
          adr_d  = wb_adr_i[ADR_WIDTH+1:2];
          ce_n_d = 2'b00;
          if (wb_we_i) begin
            state_d  = S_WSETUP;
            dat_oe_d = 1'b1;
            dat_o_d  = wb_dat_i;
            ub_n_d   = {~wb_sel_i[3], ~wb_sel_i[1]};
            lb_n_d   = {~wb_sel_i[2], ~wb_sel_i[0]};
          end else begin
            state_d = S_READ;
            oe_n_d  = 1'b0;
            ub_n_d  = 2'b00;
            lb_n_d  = 2'b00;
            cnt_d   = RD_LOAD;
          end
        end
      end
      S_READ: begin
        if (cnt_q == '0) begin
          state_d = S_ACK;
          rdata_d = sram_dat_i;
          ack_d   = wb_cyc_i;
          ce_n_d  = 2'b11;
          oe_n_d  = 1'b1;
          ub_n_d  = 2'b11;
          lb_n_d  = 2'b11;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_WSETUP: begin
        state_d = S_WPULSE;
        we_n_d  = 1'b0;
        cnt_d   = WR_LOAD;
      end
      S_WPULSE: begin
        // The pulse always runs to full length even if the master gives up
        if (cnt_q == '0) begin
          state_d = S_WHOLD;
          we_n_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_WHOLD: begin
        state_d  = S_ACK;
        ack_d    = wb_cyc_i;
        dat_oe_d = 1'b0;
        ce_n_d   = 2'b11;
        ub_n_d   = 2'b11;
        lb_n_d   = 2'b11;
      end
      S_ACK: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d  = S_IDLE;
        dat_oe_d = 1'b0;
        ce_n_d   = 2'b11;
        oe_n_d   = 1'b1;
        we_n_d   = 1'b1;
        ub_n_d   = 2'b11;
        lb_n_d   = 2'b11;
      end
    endcase
  end

  // State, counter and all registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      adr_q    <= '0;
      dat_o_q  <= '0;
      rdata_q  <= '0;
      dat_oe_q <= 1'b0;
      ce_n_q   <= 2'b11;
      oe_n_q   <= 1'b1;
      we_n_q   <= 1'b1;
      ub_n_q   <= 2'b11;
      lb_n_q   <= 2'b11;
      ack_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      adr_q    <= adr_d;
      dat_o_q  <= dat_o_d;
      rdata_q  <= rdata_d;
      dat_oe_q <= dat_oe_d;
      ce_n_q   <= ce_n_d;
      oe_n_q   <= oe_n_d;
      we_n_q   <= we_n_d;
      ub_n_q   <= ub_n_d;
      lb_n_q   <= lb_n_d;
      ack_q    <= ack_d;
    end
  end

  assign wb_dat_o    = rdata_q;
  assign wb_ack_o    = ack_q;
  assign sram_adr    = adr_q;
  assign sram_dat_o  = dat_o_q;
  assign sram_dat_oe = dat_oe_q;
  assign sram_ce_n   = ce_n_q;
  assign sram_oe_n   = oe_n_q;
  assign sram_we_n   = we_n_q;
  assign sram_ub_n   = ub_n_q;
  assign sram_lb_n   = lb_n_q;

endmodule
`default_nettype wire

// File: tb/tb_sram_wb_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_wb_ctrl
// Purpose  : Self-checking bench for sram_wb_ctrl with an asynchronous SRAM
//            model and a read-data scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_wb_ctrl;

  localparam int ADR_WIDTH = 18;
  localparam int RD_WAIT   = 2;
  localparam int WR_WAIT   = 1;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 wb_cyc_i = 1'b0, wb_stb_i = 1'b0, wb_we_i = 1'b0;
  logic [31:0]          wb_adr_i = '0, wb_dat_i = '0;
  logic [3:0]           wb_sel_i = '0;
  logic [31:0]          wb_dat_o;
  logic                 wb_ack_o;
  logic [ADR_WIDTH-1:0] sram_adr;
  logic [31:0]          sram_dat_o, sram_dat_i;
  logic                 sram_dat_oe, sram_oe_n, sram_we_n;
  logic [1:0]           sram_ce_n, sram_ub_n, sram_lb_n;

  sram_wb_ctrl #(.ADR_WIDTH(ADR_WIDTH), .RD_WAIT(RD_WAIT), .WR_WAIT(WR_WAIT)) dut (
    .clk(clk), .rst(rst),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
    .wb_adr_i(wb_adr_i), .wb_sel_i(wb_sel_i), .wb_dat_i(wb_dat_i),
    .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
    .sram_adr(sram_adr), .sram_dat_o(sram_dat_o), .sram_dat_i(sram_dat_i),
    .sram_dat_oe(sram_dat_oe), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n), .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // SRAM model: 256 words is plenty for this bench; byte lanes gated per chip
  logic [31:0] mem     [0:255];
  logic [31:0] ref_mem [0:255];
  logic [31:0] sb [$];

  assign sram_dat_i[31:16] = (!sram_ce_n[1] && !sram_oe_n) ? mem[sram_adr[7:0]][31:16] : 16'h0;
  assign sram_dat_i[15:0]  = (!sram_ce_n[0] && !sram_oe_n) ? mem[sram_adr[7:0]][15:0]  : 16'h0;

  always @(posedge clk) begin
    if (!sram_we_n) begin
      if (!sram_ce_n[0] && !sram_lb_n[0]) mem[sram_adr[7:0]][7:0]   <= sram_dat_o[7:0];
      if (!sram_ce_n[0] && !sram_ub_n[0]) mem[sram_adr[7:0]][15:8]  <= sram_dat_o[15:8];
      if (!sram_ce_n[1] && !sram_lb_n[1]) mem[sram_adr[7:0]][23:16] <= sram_dat_o[23:16];
      if (!sram_ce_n[1] && !sram_ub_n[1]) mem[sram_adr[7:0]][31:24] <= sram_dat_o[31:24];
    end
  end

  // Strobe monitor on the falling edge, away from the active edge
  int          we_low = 0, oe_low = 0, ack_seen = 0, exp_acks = 0;
  logic        unstable = 1'b0, prev_oe = 1'b0;
  logic [31:0] prev_dat = '0;
  logic [1:0]  pulse_ub = 2'b11, pulse_lb = 2'b11;
  logic [31:0] pulse_adr = '0;

  always @(negedge clk) begin
    chk("oe_we_overlap", {31'd0, (!sram_oe_n && !sram_we_n)}, 32'd0);
    if (!sram_we_n) begin
      we_low++;
      pulse_ub  = sram_ub_n;
      pulse_lb  = sram_lb_n;
      pulse_adr = 32'(sram_adr);
    end
    if (!sram_oe_n) oe_low++;
    if (wb_ack_o) ack_seen++;
    if (sram_dat_oe && prev_oe && (sram_dat_o !== prev_dat)) unstable = 1'b1;
    prev_oe  = sram_dat_oe;
    prev_dat = sram_dat_o;
  end

  // One complete Wishbone access; latency is counted in edges after accept
  task automatic bus(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                     input logic [31:0] dat, input string tag);
    int lat;
    int exp_lat;
    logic [ADR_WIDTH-1:0] w;
    logic [31:0] e;
    w       = adr[ADR_WIDTH+1:2];
    exp_lat = we ? (WR_WAIT + 2) : RD_WAIT;
    if (we) begin
      for (int b = 0; b < 4; b++)
        if (sel[b]) ref_mem[w[7:0]][8*b +: 8] = dat[8*b +: 8];
    end else begin
      sb.push_back(ref_mem[w[7:0]]);
    end
    @(negedge clk);
    we_low = 0; oe_low = 0; unstable = 1'b0;
    pulse_ub = 2'b11; pulse_lb = 2'b11;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
    wb_adr_i = adr; wb_sel_i = sel; wb_dat_i = dat;
    exp_acks++;
    @(posedge clk);
    lat = 0;
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      @(posedge clk); #1;
      if (wb_ack_o) lat = i;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    if (!we && sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_rdata"}, wb_dat_o, e);
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = '0;
      ref_mem[i] = '0;
    end

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ce_n", 32'(sram_ce_n), 32'h3);
    chk("rst_oe_we", {30'd0, sram_oe_n, sram_we_n}, 32'h3);
    chk("rst_ub_lb", {28'd0, sram_ub_n, sram_lb_n}, 32'hF);
    chk("rst_oe_ack", {30'd0, sram_dat_oe, wb_ack_o}, 32'h0);
    chk("rst_adr", 32'(sram_adr), 32'h0);
    chk("rst_dat", sram_dat_o | wb_dat_o, 32'h0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Full-word write
    bus(1'b1, 32'h4000_0010, 4'hF, 32'hDEAD_BEEF, "wr_full");
    chk("wr_full_adr", pulse_adr, 32'h4);
    chk("wr_full_welow", 32'(we_low), 32'd1);
    chk("wr_full_stable", {31'd0, unstable}, 32'd0);
    chk("wr_full_lanes", {28'd0, pulse_ub, pulse_lb}, 32'h0);

    // Read it back
    bus(1'b0, 32'h4000_0010, 4'hF, 32'h0, "rd_full");
    chk("rd_full_oelow", 32'(oe_low), 32'd2);

    // Byte write to lane 0 only, then read-modify check
    bus(1'b1, 32'h4000_0010, 4'h1, 32'h0000_00AA, "wr_byte");
    chk("wr_byte_lanes", {28'd0, pulse_ub, pulse_lb}, 32'b1110);
    bus(1'b0, 32'h4000_0010, 4'hF, 32'h0, "rd_byte");

    // Address above the window aliases to the same word
    bus(1'b0, 32'h4010_0010, 4'hF, 32'h0, "rd_alias");

    // Write with no byte selected still completes and leaves memory unchanged
    bus(1'b1, 32'h4000_0010, 4'h0, 32'h1234_5678, "wr_sel0");
    chk("wr_sel0_lanes", {28'd0, pulse_ub, pulse_lb}, 32'hF);
    bus(1'b0, 32'h4000_0010, 4'hF, 32'h0, "rd_sel0");

    // Reset while the write pulse is active
    @(negedge clk);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
    wb_adr_i = 32'h4000_0080; wb_sel_i = 4'hF; wb_dat_i = 32'hCAFE_F00D;
    @(posedge clk); @(posedge clk); #1;
    chk("rstmid_inpulse", {31'd0, sram_we_n}, 32'd0);
    @(negedge clk);
    rst = 1'b1; wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    @(posedge clk); #1;
    chk("rstmid_we_n", {31'd0, sram_we_n}, 32'd1);
    chk("rstmid_ce_n", 32'(sram_ce_n), 32'h3);
    chk("rstmid_oe_ack", {30'd0, sram_dat_oe, wb_ack_o}, 32'h0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    bus(1'b0, 32'h4000_0010, 4'hF, 32'h0, "rd_after_rst");

    // Master abandons a read while OE is active
    @(negedge clk);
    ack_seen = 0;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0;
    wb_adr_i = 32'h4000_0010; wb_sel_i = 4'hF;
    @(posedge clk); #1;
    chk("abort_inread", {31'd0, sram_oe_n}, 32'd0);
    @(negedge clk); wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("abort_noack", 32'(ack_seen), 32'd0);
    chk("abort_idle_strobes", {28'd0, sram_ce_n, sram_oe_n, sram_we_n}, 32'hF);
    ack_seen  = 0;
    exp_acks  = 0;
    bus(1'b0, 32'h4000_0010, 4'hF, 32'h0, "rd_after_abort");

    // Random mix of reads and writes over a few aliased words
    for (int n = 0; n < 24; n++) begin
      logic [31:0] a;
      a = 32'h4000_0000 | (32'($urandom_range(0, 7)) << 2) | (32'($urandom_range(0, 1)) << 20);
      bus(1'($urandom_range(0, 1)), a, 4'($urandom), $urandom, "rand");
    end
    @(negedge clk);
    chk("ack_count", 32'(ack_seen), 32'(exp_acks));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute bound so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/sram_wb_ctrl.md
Name: sram_wb_ctrl

Overview:
Wishbone classic slave that sequences the two external 256Kx16 asynchronous SRAMs on the Spartan-3 starter kit as one 32-bit word-wide memory. It sits on conbus slave port s0 (base 0x40000000). It generates registered, glitch-free CE/OE/WE/byte-enable strobes with programmable wait states, so the LM32 can use external RAM alongside block RAM.

Parameters:
adr_width, 18, SRAM word-address width; the word address is taken from wb_adr_i[adr_width+1:2].
rd_wait, 2, number of cycles OE is held before read data is captured; minimum 1.
wr_wait, 1, number of cycles WE is held low; minimum 1.

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
wb_cyc_i  in  1  Wishbone cycle
wb_stb_i  in  1  Wishbone strobe
wb_we_i  in  1  write enable
wb_adr_i  in  32  byte address; bits [1:0] and bits above adr_width+1 are ignored
wb_sel_i  in  4  byte selects
wb_dat_i  in  32  write data
wb_dat_o  out  32  read data
wb_ack_o  out  1  single-cycle acknowledge
sram_adr  out  adr_width  SRAM address, shared by both chips
sram_dat_o  out  32  data to SRAM; [31:16] goes to chip1, [15:0] to chip0
sram_dat_i  in  32  data from SRAM
sram_dat_oe  out  1  drive enable for the top-level tristate buffer
sram_ce_n  out  2  chip enables {chip1, chip0}
sram_oe_n  out  1  output enable
sram_we_n  out  1  write enable
sram_ub_n  out  2  upper-byte enables {chip1, chip0}
sram_lb_n  out  2  lower-byte enables {chip1, chip0}

Behaviour:
- Interface decision: reset rst, synchronous, active-high; clock clk.
- All outputs are registered. Reset values: ce_n=2'b11, oe_n=1, we_n=1, ub_n=lb_n=2'b11, dat_oe=0, ack=0, sram_adr=0, sram_dat_o=0, wb_dat_o=0.
- FSM states: IDLE, READ, WSETUP, WPULSE, WHOLD, ACK. A wait counter sized to max(rd_wait, wr_wait) is loaded on entry to READ and to WPULSE.
- IDLE: a request is accepted when cyc&stb is high at edge E0. On that edge, register the address, set ce_n=00, and go to READ if we=0 or WSETUP if we=1.
- READ: oe_n=0 and all byte enables low, regardless of sel. Stay rd_wait cycles. On the last edge, capture sram_dat_i into wb_dat_o and go to ACK. ack is high rd_wait edges after E0.
- WSETUP (1 cycle): dat_oe=1, sram_dat_o=wb_dat_i, byte enables from sel. sel[3] maps to ub_n[1], sel[2] to lb_n[1], sel[1] to ub_n[0], sel[0] to lb_n[0]. we_n stays 1.
- WPULSE: we_n=0 for wr_wait cycles.
- WHOLD (1 cycle): we_n=1, with address, data and dat_oe still held. ack is high wr_wait+2 edges after E0.
- ACK (1 cycle): ack=1 if cyc is still high. ce_n=11, oe_n=1, dat_oe=0, byte enables all 1. Next state is IDLE. Back-to-back requests are therefore spaced by at least one IDLE cycle.
- Abort: if cyc drops mid-access, the SRAM access still completes (a WE pulse is never truncated), ack is suppressed, and the FSM returns to IDLE.
- sel=0 on a write: run the full sequence with no byte enabled, then ack.
- Reset mid-operation: on the next edge all strobes are deasserted, the FSM is in IDLE and no ack is issued.
- Address wrap: addresses beyond the 1 MB window alias modulo 2^adr_width words.
- Invariants: oe_n and we_n are never low together. dat_oe=1 only in WSETUP, WPULSE and WHOLD.

Decomposition:
- Shared package: FSM state encodings (3-bit localparams), the SRAM_BASE constant 4'h4 used by the interconnect, and the minimum wait constant 1.
- No sub-module is needed: a single module with one FSM and one down-counter.

Test Plan:
- Write 0xDEADBEEF to 0x40000010 with sel=1111, rd_wait=2, wr_wait=1. Required: sram_adr=4, we_n low for exactly 1 cycle with data stable from WSETUP through WHOLD, and ack 3 edges after accept.
- Read back 0x40000010 with the SRAM model returning the stored word. Required: wb_dat_o=0xDEADBEEF, ack 2 edges after accept, and oe_n low for 2 cycles.
- Byte write of 0x000000AA with sel=0001, then a read. Required: only lb_n[0]=0 during the pulse, and the read returns 0xDEADBEAA.
- Assert rst during WPULSE. Required: next cycle we_n=1, ce_n=11, dat_oe=0, ack=0, and the state is IDLE.
- Drop cyc in READ. Required: no ack, the FSM reaches IDLE, and a following read completes normally.
- Random back-to-back reads and writes against the SRAM model with assertions. Required: oe_n and we_n are never low together, and one ack is issued per accepted cycle.
